// File: rtl/zorro_arb_pkg.sv
// Shared definitions for the Zorro III slot arbiter and the blocks that decode its state.
//   bm_state_e  : bus-master state encodings driven on bm_state
//   SLOT_IDX_W  : width of a slot index for a given slot count (never below 1)
package zorro_arb_pkg;

    typedef enum logic [1:0] {
        BM_IDLE    = 2'b00,
        BM_GRANT   = 2'b01,
        BM_OWNED   = 2'b10,
        BM_RELEASE = 2'b11
    } bm_state_e;

    function automatic int unsigned SLOT_IDX_W(input int unsigned num_slots);
        return (num_slots > 1) ? $clog2(num_slots) : 1;
    endfunction

endpackage

// File: rtl/zorro_slot_arbiter_if.sv
// Slot-side bus signals of the Zorro III arbiter.
//   ebr_n_in      : slot bus requests, active low, asynchronous
//   ebgack_n_in   : wired-OR grant acknowledge, active low, asynchronous
//   ebg_n_out     : slot bus grants, active low
//   ebg_n_oe      : grant output enables
//   bm_state      : arbiter state (bm_state_e encoding)
//   grant_slot    : index of the current/last granted slot
//   slot_owns_bus : an external master drives the bus
//   timeout_pulse : one-cycle pulse when an unacknowledged grant is withdrawn
// master = arbiter side, slave = slot side.
interface zorro_slot_arbiter_if
    import zorro_arb_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 5
);
    localparam int unsigned IDX_W = SLOT_IDX_W(NUM_SLOTS);

    logic [NUM_SLOTS-1:0] ebr_n_in;
    logic                 ebgack_n_in;
    logic [NUM_SLOTS-1:0] ebg_n_out;
    logic [NUM_SLOTS-1:0] ebg_n_oe;
    logic [1:0]           bm_state;
    logic [IDX_W-1:0]     grant_slot;
    logic                 slot_owns_bus;
    logic                 timeout_pulse;

    modport master (
        input  ebr_n_in, ebgack_n_in,
        output ebg_n_out, ebg_n_oe, bm_state, grant_slot, slot_owns_bus, timeout_pulse
    );

    modport slave (
        output ebr_n_in, ebgack_n_in,
        input  ebg_n_out, ebg_n_oe, bm_state, grant_slot, slot_owns_bus, timeout_pulse
    );

endinterface

// File: rtl/zorro_rr_pick.sv
// Combinational winner selection among slot requests.
//   req     : active-high request vector
//   pointer : first slot to consider in rotating mode (must be < NUM_SLOTS)
//   rr_mode : 1 = search upward from pointer with wrap, 0 = lowest index wins
//   valid   : at least one request present
//   index   : winning slot
module zorro_rr_pick
    import zorro_arb_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 5,
    localparam int unsigned IDX_W = SLOT_IDX_W(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] req,
    input  logic [IDX_W-1:0]     pointer,
    input  logic                 rr_mode,
    output logic                 valid,
    output logic [IDX_W-1:0]     index
);

    logic [IDX_W-1:0]       base;
    logic [2*NUM_SLOTS-1:0] dbl;
    logic [NUM_SLOTS-1:0]   rot;
    int unsigned            off;
    int unsigned            sum;

    always_comb begin
        base  = rr_mode ? pointer : '0;
        // Rotate so that bit 0 of rot is slot 'base'; the lowest set bit is the winner.
        dbl   = {req, req} >> base;
        rot   = dbl[NUM_SLOTS-1:0];
        valid = 1'b0;
        off   = 0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!valid && rot[i]) begin
                valid = 1'b1;
                off   = i;
            end
        end
        sum = 32'(base) + off;
        if (sum >= NUM_SLOTS) begin
            sum = sum - NUM_SLOTS;
        end
        index = IDX_W'(sum);
    end

endmodule

// File: rtl/zorro_slot_arbiter.sv
// Zorro III expansion-slot bus arbiter.
//   clk100            : 100 MHz system clock
//   reset_n_in        : asynchronous active-low reset
//   cpuclk_rising     : one-cycle strobe at the CPU clock rising edge
//   access_state_idle : access block idle; new grants only while high
//   bus               : slot request/grant/ack signals and status (master modport)
// Requests and ack are synchronised, a winner is granted on a CPU strobe while the access
// block is idle, and ownership is tracked through the acknowledge until release.
module zorro_slot_arbiter
    import zorro_arb_pkg::*;
#(
    parameter int unsigned NUM_SLOTS      = 5,
    parameter int unsigned ROUND_ROBIN    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                 clk100,
    input  logic                 reset_n_in,
    input  logic                 cpuclk_rising,
    input  logic                 access_state_idle,
    zorro_slot_arbiter_if.master bus
);

    localparam int unsigned IDX_W    = SLOT_IDX_W(NUM_SLOTS);
    localparam int unsigned TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0][NUM_SLOTS-1:0] ebr_sync_q;
    logic [SYNC_STAGES-1:0]                ack_sync_q;

    bm_state_e            state_q, state_d;
    logic [NUM_SLOTS-1:0] ebg_q, ebg_d;
    logic [NUM_SLOTS-1:0] oe_q;
    logic [IDX_W-1:0]     gslot_q, gslot_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 pulse_q, pulse_d;
    logic                 owns_q;

    logic [NUM_SLOTS-1:0] req;
    logic                 ack;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [NUM_SLOTS-1:0] own_mask;
    logic [IDX_W-1:0]     next_ptr;

    always_ff @(posedge clk100 or negedge reset_n_in) begin
        if (!reset_n_in) begin
            ebr_sync_q <= '1;
            ack_sync_q <= '1;
        end else begin
            ebr_sync_q <= {ebr_sync_q[SYNC_STAGES-2:0], bus.ebr_n_in};
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.ebgack_n_in};
        end
    end

    assign req      = ~ebr_sync_q[SYNC_STAGES-1];
    assign ack      = ~ack_sync_q[SYNC_STAGES-1];
    assign own_mask = NUM_SLOTS'(1) << gslot_q;
    assign next_ptr = (gslot_q == IDX_W'(NUM_SLOTS - 1)) ? '0 : gslot_q + IDX_W'(1);

    zorro_rr_pick #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_pick (
        .req     (req),
        .pointer (ptr_q),
        .rr_mode (ROUND_ROBIN != 0),
        .valid   (pick_valid),
        .index   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ebg_d   = ebg_q;
        gslot_d = gslot_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        pulse_d = 1'b0;
        unique case (state_q)
            BM_IDLE: begin
                if (cpuclk_rising && access_state_idle && pick_valid) begin
                    state_d = BM_GRANT;
                    gslot_d = pick_idx;
                    timer_d = '0;
                    ebg_d   = ~(NUM_SLOTS'(1) << pick_idx);
                end
            end
            BM_GRANT: begin
                // Ack outranks both withdrawal and timeout in the same cycle.
                if (ack) begin
                    state_d = BM_OWNED;
                    if (ROUND_ROBIN != 0) begin
                        ptr_d = next_ptr;
                    end
                end else if ((req & own_mask) == '0) begin
                    ebg_d   = '1;
                    state_d = BM_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    ebg_d   = '1;
                    pulse_d = 1'b1;
                    ptr_d   = next_ptr;
                    state_d = BM_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            BM_OWNED: begin
                if (!ack) begin
                    ebg_d   = '1;
                    state_d = BM_RELEASE;
                end else if (((req & own_mask) == '0) || ((req & ~own_mask) != '0)) begin
                    // Raising EBG asks the owner to get off the bus; it is never re-lowered.
                    ebg_d = '1;
                end
            end
            BM_RELEASE: begin
                ebg_d   = '1;
                state_d = BM_IDLE;
            end
            default: begin
                ebg_d   = '1;
                state_d = BM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk100 or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= BM_IDLE;
            ebg_q   <= '1;
            oe_q    <= '0;
            gslot_q <= '0;
            ptr_q   <= '0;
            timer_q <= '0;
            pulse_q <= 1'b0;
            owns_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ebg_q   <= ebg_d;
            oe_q    <= '1;
            gslot_q <= gslot_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
            owns_q  <= (state_d == BM_OWNED);
        end
    end

    assign bus.ebg_n_out     = ebg_q;
    assign bus.ebg_n_oe      = oe_q;
    assign bus.bm_state      = state_q;
    assign bus.grant_slot    = gslot_q;
    assign bus.slot_owns_bus = owns_q;
    assign bus.timeout_pulse = pulse_q;

endmodule

// File: tb/tb_zorro_slot_arbiter.sv
// Bench for zorro_slot_arbiter: a rotating-priority and a fixed-priority instance share the
// request lines and are compared every cycle against a transaction-level reference model.
module tb_zorro_slot_arbiter;
    import zorro_arb_pkg::*;

    localparam int unsigned N = 5;
    localparam int unsigned T = 16;
    localparam int unsigned S = 2;

    logic clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    logic         reset_n_in;
    logic         cpuclk_rising;
    logic         access_state_idle;
    logic [N-1:0] ebr_n;
    logic         ack_n [2];

    zorro_slot_arbiter_if #(.NUM_SLOTS(N)) bus_rr ();
    zorro_slot_arbiter_if #(.NUM_SLOTS(N)) bus_fx ();

    assign bus_rr.ebr_n_in    = ebr_n;
    assign bus_fx.ebr_n_in    = ebr_n;
    assign bus_rr.ebgack_n_in = ack_n[0];
    assign bus_fx.ebgack_n_in = ack_n[1];

    zorro_slot_arbiter #(
        .NUM_SLOTS(N), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(T), .SYNC_STAGES(S)
    ) u_dut_rr (
        .clk100(clk100), .reset_n_in(reset_n_in), .cpuclk_rising(cpuclk_rising),
        .access_state_idle(access_state_idle), .bus(bus_rr)
    );

    zorro_slot_arbiter #(
        .NUM_SLOTS(N), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(T), .SYNC_STAGES(S)
    ) u_dut_fx (
        .clk100(clk100), .reset_n_in(reset_n_in), .cpuclk_rising(cpuclk_rising),
        .access_state_idle(access_state_idle), .bus(bus_fx)
    );

    logic [N-1:0] o_ebg [2];
    logic [N-1:0] o_oe [2];
    logic [1:0]   o_state [2];
    logic [2:0]   o_gslot [2];
    logic         o_owns [2];
    logic         o_pulse [2];

    assign o_ebg[0] = bus_rr.ebg_n_out;       assign o_ebg[1] = bus_fx.ebg_n_out;
    assign o_oe[0] = bus_rr.ebg_n_oe;         assign o_oe[1] = bus_fx.ebg_n_oe;
    assign o_state[0] = bus_rr.bm_state;      assign o_state[1] = bus_fx.bm_state;
    assign o_gslot[0] = bus_rr.grant_slot;    assign o_gslot[1] = bus_fx.grant_slot;
    assign o_owns[0] = bus_rr.slot_owns_bus;  assign o_owns[1] = bus_fx.slot_owns_bus;
    assign o_pulse[0] = bus_rr.timeout_pulse; assign o_pulse[1] = bus_fx.timeout_pulse;

    // Reference model: 0 idle, 1 grant, 2 owned, 3 release.
    int           m_st [2];
    int           m_w [2];
    int           m_ptr [2];
    int           m_timer [2];
    logic [N-1:0] m_ebg [2];
    logic         m_oe [2];
    logic         m_owns [2];
    logic         m_pulse [2];
    bit           m_granted [2];
    logic [N-1:0] m_ebr_hist [2][S];
    logic         m_ack_hist [2][S];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rand_mode = 1'b0;
    bit agent_on  = 1'b0;
    int glog_rr [$];
    int glog_fx [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] req, input int ptr, input bit rr);
        int start = rr ? ptr : 0;
        for (int k = 0; k < N; k++) begin
            int s = (start + k) % N;
            if (req[s]) return s;
        end
        return 0;
    endfunction

    task automatic model_reset(input int d);
        m_st[d] = 0; m_w[d] = 0; m_ptr[d] = 0; m_timer[d] = 0;
        m_ebg[d] = '1; m_oe[d] = 1'b0; m_owns[d] = 1'b0; m_pulse[d] = 1'b0;
        m_granted[d] = 1'b0;
        for (int k = 0; k < S; k++) begin
            m_ebr_hist[d][k] = '1;
            m_ack_hist[d][k] = 1'b1;
        end
    endtask

    task automatic model_step(input int d);
        logic [N-1:0] req = ~m_ebr_hist[d][S-1];
        bit           acked = !m_ack_hist[d][S-1];
        bit           rr = (d == 0);
        logic [N-1:0] wmask = N'(1) << m_w[d];
        m_pulse[d] = 1'b0;
        m_granted[d] = 1'b0;
        m_oe[d] = 1'b1;
        case (m_st[d])
            0: if (cpuclk_rising && access_state_idle && req != '0) begin
                m_w[d] = model_pick(req, m_ptr[d], rr);
                m_ebg[d] = ~(N'(1) << m_w[d]);
                m_timer[d] = 0;
                m_st[d] = 1;
                m_granted[d] = 1'b1;
            end
            1: if (acked) begin
                m_st[d] = 2;
                if (rr) m_ptr[d] = (m_w[d] + 1) % N;
            end else if ((req & wmask) == '0) begin
                m_ebg[d] = '1;
                m_st[d] = 0;
            end else if (m_timer[d] == T - 1) begin
                m_ebg[d] = '1;
                m_pulse[d] = 1'b1;
                m_ptr[d] = (m_w[d] + 1) % N;
                m_st[d] = 0;
            end else begin
                m_timer[d]++;
            end
            2: if (!acked) begin
                m_ebg[d] = '1;
                m_st[d] = 3;
            end else if ((req & wmask) == '0 || (req & ~wmask) != '0) begin
                m_ebg[d] = '1;
            end
            default: begin
                m_ebg[d] = '1;
                m_st[d] = 0;
            end
        endcase
        m_owns[d] = (m_st[d] == 2);
        for (int k = S - 1; k > 0; k--) begin
            m_ebr_hist[d][k] = m_ebr_hist[d][k-1];
            m_ack_hist[d][k] = m_ack_hist[d][k-1];
        end
        m_ebr_hist[d][0] = ebr_n;
        m_ack_hist[d][0] = ack_n[d];
    endtask

    task automatic check_model();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d ebg_n_out", d), o_ebg[d], m_ebg[d]);
            check_eq($sformatf("d%0d ebg_n_oe", d), o_oe[d], {N{m_oe[d]}});
            check_eq($sformatf("d%0d bm_state", d), o_state[d], m_st[d]);
            check_eq($sformatf("d%0d grant_slot", d), o_gslot[d], m_w[d]);
            check_eq($sformatf("d%0d slot_owns_bus", d), o_owns[d], m_owns[d]);
            check_eq($sformatf("d%0d timeout_pulse", d), o_pulse[d], m_pulse[d]);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk100);
        for (int d = 0; d < 2; d++) begin
            if (!reset_n_in) model_reset(d);
            else model_step(d);
        end
        @(negedge clk100);
        check_model();
        if (m_granted[0]) glog_rr.push_back(int'(o_gslot[0]));
        if (m_granted[1]) glog_fx.push_back(int'(o_gslot[1]));
        cyc++;
        cpuclk_rising = rand_mode ? ($urandom_range(0, 3) == 0) : (cyc % 4 == 0);
        if (agent_on) begin
            for (int d = 0; d < 2; d++) ack_n[d] = &o_ebg[d];
        end
    endtask

    task automatic wait_state(input int d, input int st, input int budget, input string tag);
        int n = 0;
        while (m_st[d] != st && n < budget) begin
            step_cycle();
            n++;
        end
        if (m_st[d] != st) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: state %0d not reached in %0d cycles, got %0d", tag, st, budget,
                     m_st[d]);
        end
    endtask

    task automatic pulse_reset();
        reset_n_in = 1'b0;
        step_cycle();
        reset_n_in = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("%s d%0d ebg", tag, d), o_ebg[d], 32'h1f);
            check_eq($sformatf("%s d%0d oe", tag, d), o_oe[d], 32'h0);
            check_eq($sformatf("%s d%0d state", tag, d), o_state[d], 32'h0);
            check_eq($sformatf("%s d%0d owns", tag, d), o_owns[d], 32'h0);
            check_eq($sformatf("%s d%0d pulse", tag, d), o_pulse[d], 32'h0);
        end
    endtask

    initial begin
        int grant_cycles;
        int pulses;
        int n;

        reset_n_in = 1'b0;
        cpuclk_rising = 1'b0;
        access_state_idle = 1'b1;
        ebr_n = '1;
        ack_n[0] = 1'b1;
        ack_n[1] = 1'b1;
        model_reset(0);
        model_reset(1);
        repeat (3) @(negedge clk100);
        check_reset_values("reset");
        check_eq("reset d0 grant_slot", o_gslot[0], 32'h0);
        reset_n_in = 1'b1;
        step_cycle();

        // Single request from slot 2, then release.
        ebr_n = 5'b11011;
        wait_state(0, 1, 20, "single grant");
        check_eq("single ebg rr", o_ebg[0], 32'h1b);
        check_eq("single ebg fx", o_ebg[1], 32'h1b);
        ack_n[0] = 1'b0;
        ack_n[1] = 1'b0;
        wait_state(0, 2, 10, "single owned");
        check_eq("single owned state", o_state[0], 32'h2);
        ebr_n = '1;
        ack_n[0] = 1'b1;
        ack_n[1] = 1'b1;
        wait_state(0, 3, 10, "single release");
        check_eq("single release state", o_state[0], 32'h3);
        step_cycle();
        check_eq("single back idle", o_state[0], 32'h0);
        check_eq("single ebg idle", o_ebg[0], 32'h1f);

        // Fairness: slots 0 and 3 request continuously and release when preempted.
        pulse_reset();
        glog_rr.delete();
        glog_fx.delete();
        agent_on = 1'b1;
        ebr_n = 5'b10110;
        n = 0;
        while ((glog_rr.size() < 4 || glog_fx.size() < 4) && n < 600) begin
            step_cycle();
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("rr order %0d", i),
                     (i < glog_rr.size()) ? glog_rr[i] : 32'hffff_ffff, (i % 2 == 0) ? 0 : 3);
            check_eq($sformatf("fixed order %0d", i),
                     (i < glog_fx.size()) ? glog_fx[i] : 32'hffff_ffff, 0);
        end

        // Preemption: slot 4 owns the bus, slot 0 starts requesting.
        ebr_n = '1;
        wait_state(0, 0, 40, "preempt settle0");
        wait_state(1, 0, 40, "preempt settle1");
        ebr_n = 5'b01111;
        wait_state(0, 2, 40, "preempt owned");
        agent_on = 1'b0;
        ack_n[0] = 1'b0;
        ack_n[1] = 1'b0;
        ebr_n = 5'b01110;
        repeat (6) step_cycle();
        check_eq("preempt still owned", o_state[0], 32'h2);
        check_eq("preempt ebg raised", o_ebg[0], 32'h1f);
        ebr_n = 5'b11110;
        ack_n[0] = 1'b1;
        ack_n[1] = 1'b1;
        wait_state(0, 1, 40, "preempt regrant");
        check_eq("preempt new slot", o_gslot[0], 32'h0);
        check_eq("preempt new ebg", o_ebg[0], 32'h1e);

        // Timeout: slot 1 is granted and never acknowledges; slot 3 joins meanwhile.
        ebr_n = '1;
        wait_state(0, 0, 40, "timeout settle0");
        wait_state(1, 0, 40, "timeout settle1");
        ebr_n = 5'b11101;
        grant_cycles = 0;
        pulses = 0;
        n = 0;
        glog_rr.delete();
        glog_fx.delete();
        while (glog_rr.size() < 2 && n < 100) begin
            step_cycle();
            n++;
            if (o_state[0] == 2'd1 && pulses == 0) grant_cycles++;
            if (o_pulse[0]) pulses++;
            if (grant_cycles == 5) ebr_n = 5'b10101;
        end
        check_eq("timeout grant cycles", grant_cycles, T);
        check_eq("timeout pulses", pulses, 1);
        check_eq("timeout next rr", (glog_rr.size() > 1) ? glog_rr[1] : 32'hffff_ffff, 3);
        check_eq("timeout next fixed", (glog_fx.size() > 1) ? glog_fx[1] : 32'hffff_ffff, 1);

        // Gating by access_state_idle.
        ebr_n = '1;
        wait_state(0, 0, 40, "gate settle0");
        wait_state(1, 0, 40, "gate settle1");
        access_state_idle = 1'b0;
        ebr_n = 5'b10111;
        repeat (20) step_cycle();
        check_eq("gate no grant", o_state[0], 32'h0);
        check_eq("gate ebg high", o_ebg[0], 32'h1f);
        access_state_idle = 1'b1;
        wait_state(0, 1, 20, "gate grant");
        check_eq("gate grant slot", o_gslot[0], 32'h3);

        // Random traffic.
        ebr_n = '1;
        rand_mode = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            if (c % 100 == 0) agent_on = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) == 0) ebr_n = ebr_n ^ (N'(1) << $urandom_range(0, N - 1));
            access_state_idle = ($urandom_range(0, 7) != 0);
            if (!agent_on) begin
                for (int d = 0; d < 2; d++) begin
                    if ($urandom_range(0, 11) == 0) ack_n[d] = ~ack_n[d];
                end
            end
            step_cycle();
        end

        // Reset while a slot owns the bus.
        rand_mode = 1'b0;
        access_state_idle = 1'b1;
        agent_on = 1'b1;
        ebr_n = '1;
        wait_state(0, 0, 60, "rst settle0");
        wait_state(1, 0, 60, "rst settle1");
        ebr_n = 5'b11110;
        wait_state(0, 2, 40, "rst owned");
        step_cycle();
        #2 reset_n_in = 1'b0;
        #1 check_reset_values("mid-owned reset");
        step_cycle();
        reset_n_in = 1'b1;
        ebr_n = '1;
        repeat (8) step_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
